mem_stub: RTL and testbench
===========================

# mem_stub

Parametrised default slave/terminator for the memory bus, placed on unused memory ports of the SoC. Each of NCH slave channels accepts requests, queues them in order, and returns the request code and transaction ID after a fixed latency, with a configurable MESI grant. Per-channel locking stalls responses. Overflows are counted. The master side of every channel is tied off to idle.

## Interface
Parameters:
- NCH, 2: number of independent slave channels.
- LAT, 1: response latency in cycles; legal range is ≥1.
- DEPTH, 4: outstanding-request FIFO depth per channel; legal range is ≥1.
- MESI, 1: 8-bit MESI code returned with every response.

Ports (channel c occupies slice [8c+7:8c], [64c+63:64c] or [16c+15:16c]):
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_mem_lock  in  NCH  per-channel response stall.
- s_mem_rqst  in  8·NCH  request code; nonzero means a request is valid this cycle.
- s_mem_trsc  in  8·NCH  transaction ID of the request.
- s_mem_addr  in  64·NCH  request address; ignored.
- s_mem_resp  out  8·NCH  response code; nonzero for exactly one cycle per response.
- s_mem_rtrc  out  8·NCH  transaction ID echoed with the response.
- s_mem_mesi  out  8·NCH  MESI code.
- s_mem_ovf  out  NCH  sticky overflow flag.
- s_mem_drop  out  16·NCH  saturating dropped-request count.
- m_mem_lock  out  NCH  master tie-off.
- m_mem_rqst, m_mem_trsc  out  8·NCH  master tie-off.
- m_mem_addr  out  64·NCH  master tie-off.
- m_mem_resp, m_mem_mesi  in  8·NCH  ignored.

## Operation
- Each channel is independent. There is no cross-channel arbitration.
- Request acceptance: in a cycle with rqst≠0, {rqst, trsc} is pushed to the channel FIFO with a countdown of LAT−1.
- Aging: every cycle, each entry whose countdown is >0 decrements, including while lock is high.
- Head ready: the head entry is ready when its countdown is 0.
- Pop: if the head is ready and lock=0, the head pops. In the following cycle resp/rtrc show the popped {rqst, trsc} and mesi=MESI. In all other cycles resp=0, rtrc=0 and mesi=0.
- Bypass: when LAT=1, the FIFO is empty and lock=0, an incoming request is answered directly in the next cycle without occupying the FIFO. This makes LAT=1 behave as resp(t+1)=rqst(t).
- Ordering: responses are strictly in request order, at most one per channel per cycle.
- Full FIFO: a request arriving while the FIFO is full is accepted only if a pop occurs the same cycle. Otherwise it is dropped: ovf is set (sticky until rst) and drop increments, saturating at 0xFFFF.
- Empty FIFO: no response; resp=0.
- Lock: while lock=1, ready entries are held and new requests are still accepted until the FIFO is full. The first pop happens in the cycle lock is sampled 0.
- Master tie-off: m_mem_lock, m_mem_rqst, m_mem_trsc and m_mem_addr are constant 0 after reset.

## Timing
- All outputs are registered.
- Reset values: every output is 0, the FIFOs are emptied and all countdowns are cleared.
- Reset mid-operation: queued requests are discarded. No response appears in the first cycle after rst deasserts.
- Latency: a request sampled in cycle t, with lock low throughout and nothing queued ahead of it, responds in cycle t+LAT.
- Sustained throughput: one request per cycle per channel is sustained with no drops while lock=0 and DEPTH≥LAT.
- Lock release: with lock held for K≥LAT cycles starting at cycle t, a request sampled in t responds in cycle t+K+1. Subsequent queued entries respond in back-to-back cycles.
- Countdown width: clog2(LAT) bits. Occupancy count width: clog2(DEPTH+1) bits.

## Test plan
- Reset check, NCH=2, LAT=1: hold rst 3 cycles with rqst=0x05 on both channels → all outputs 0 during reset and in the first cycle after release. Then rqst=0x05, trsc=0x11 in cycle t → resp=0x05, rtrc=0x11, mesi=0x01 in cycle t+1 only.
- Latency and ordering, LAT=3, DEPTH=4: issue rqst 0x01..0x04 with trsc 0xA0..0xA3 in consecutive cycles t..t+3 → responses appear in cycles t+3..t+6 in the same order, with no drops.
- Lock and overflow, LAT=1, DEPTH=2: set lock=1 and issue 4 requests → the first 2 queue, the last 2 drop, ovf=1 and drop=2. Then release lock → 2 responses in consecutive cycles. ovf remains 1.
- Simultaneous push and pop: with the FIFO full and lock dropping, issue a request in the same cycle as the pop → the request is accepted, drop is unchanged, and it responds in order.
- Channel independence: lock channel 0 while streaming channel 1 → channel 1 responses are unaffected. Assert rst mid-stream → both queues are cleared and no stale responses appear after release.
- Drop counter saturation: force 70000 dropped requests on channel 0 → drop=0xFFFF and the count does not wrap. Master-side outputs read 0 throughout.

Source files
------------

// File: rtl/mem_stub.sv
`default_nettype none
// ============================================================================
// Module   : mem_stub
// Purpose  : Default memory-bus slave/terminator. Each channel echoes requests
//            back in order after a fixed latency; the master side is idle.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stub #(
    parameter int         NCH   = 2,
    parameter int         LAT   = 1,
    parameter int         DEPTH = 4,
    parameter logic [7:0] MESI  = 8'h01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    s_mem_lock,
    input  logic [8*NCH-1:0]  s_mem_rqst,
    input  logic [8*NCH-1:0]  s_mem_trsc,
    input  logic [64*NCH-1:0] s_mem_addr,
    output logic [8*NCH-1:0]  s_mem_resp,
    output logic [8*NCH-1:0]  s_mem_rtrc,
    output logic [8*NCH-1:0]  s_mem_mesi,
    output logic [NCH-1:0]    s_mem_ovf,
    output logic [16*NCH-1:0] s_mem_drop,
    output logic [NCH-1:0]    m_mem_lock,
    output logic [8*NCH-1:0]  m_mem_rqst,
    output logic [8*NCH-1:0]  m_mem_trsc,
    output logic [64*NCH-1:0] m_mem_addr,
    input  logic [8*NCH-1:0]  m_mem_resp,
    input  logic [8*NCH-1:0]  m_mem_mesi
);

    localparam int C_TW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int C_CW = $clog2(DEPTH + 1);
    localparam int C_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // The push cycle already counts as one aging step, so entries are stored
    // with LAT-2 remaining; this makes a lone request respond at t+LAT.
    localparam logic [C_TW-1:0] C_LOAD  = C_TW'((LAT > 1) ? LAT - 2 : 0);
    localparam logic [C_TW-1:0] C_T_ONE = C_TW'(1);
    localparam logic [C_CW-1:0] C_FULL  = C_CW'(DEPTH);
    localparam logic [C_CW-1:0] C_C_ONE = C_CW'(1);
    localparam logic [C_PW-1:0] C_LAST  = C_PW'(DEPTH - 1);
    localparam logic [C_PW-1:0] C_P_ONE = C_PW'(1);
    localparam bit              C_BYP   = (LAT == 1);

    assign m_mem_lock = '0;
    assign m_mem_rqst = '0;
    assign m_mem_trsc = '0;
    assign m_mem_addr = '0;

    logic w_unused;
    assign w_unused = ^{s_mem_addr, m_mem_resp, m_mem_mesi};

    function automatic logic [C_PW-1:0] ptr_next(input logic [C_PW-1:0] p);
        return (p == C_LAST) ? '0 : p + C_P_ONE;
    endfunction

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [7:0]      r_q_rqst [DEPTH];
        logic [7:0]      r_q_trsc [DEPTH];
        logic [C_TW-1:0] r_q_cnt  [DEPTH];
        logic [C_PW-1:0] r_rd;
        logic [C_PW-1:0] r_wr;
        logic [C_CW-1:0] r_cnt;
        logic [7:0]      r_resp;
        logic [7:0]      r_rtrc;
        logic [7:0]      r_mesi;
        logic            r_ovf;
        logic [15:0]     r_drop;

        logic [7:0] w_rqst;
        logic [7:0] w_trsc;
        logic       w_lock;
        logic       w_req;
        logic       w_empty;
        logic       w_full;
        logic       w_pop;
        logic       w_byp;
        logic       w_push;
        logic       w_drop;

        assign w_rqst  = s_mem_rqst[8*c +: 8];
        assign w_trsc  = s_mem_trsc[8*c +: 8];
        assign w_lock  = s_mem_lock[c];
        assign w_req   = (w_rqst != 8'h00);
        assign w_empty = (r_cnt == '0);
        assign w_full  = (r_cnt == C_FULL);
        assign w_pop   = !w_empty && (r_q_cnt[r_rd] == '0) && !w_lock;
        assign w_byp   = C_BYP && w_empty && !w_lock && w_req;
        // A pop in the same cycle frees the slot a full FIFO needs.
        assign w_push  = w_req && !w_byp && (!w_full || w_pop);
        assign w_drop  = w_req && w_full && !w_pop;

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_q_rqst[i] <= '0;
                    r_q_trsc[i] <= '0;
                    r_q_cnt[i]  <= '0;
                end
                r_rd   <= '0;
                r_wr   <= '0;
                r_cnt  <= '0;
                r_resp <= '0;
                r_rtrc <= '0;
                r_mesi <= '0;
                r_ovf  <= 1'b0;
                r_drop <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_q_cnt[i] != '0) begin
                        r_q_cnt[i] <= r_q_cnt[i] - C_T_ONE;
                    end
                end
                if (w_push) begin
                    r_q_rqst[r_wr] <= w_rqst;
                    r_q_trsc[r_wr] <= w_trsc;
                    r_q_cnt[r_wr]  <= C_LOAD;
                    r_wr           <= ptr_next(r_wr);
                end
                if (w_pop) begin
                    r_rd <= ptr_next(r_rd);
                end
                if (w_push && !w_pop) begin
                    r_cnt <= r_cnt + C_C_ONE;
                end else if (w_pop && !w_push) begin
                    r_cnt <= r_cnt - C_C_ONE;
                end

                if (w_pop) begin
                    r_resp <= r_q_rqst[r_rd];
                    r_rtrc <= r_q_trsc[r_rd];
                    r_mesi <= MESI;
                end else if (w_byp) begin
                    r_resp <= w_rqst;
                    r_rtrc <= w_trsc;
                    r_mesi <= MESI;
                end else begin
                    r_resp <= '0;
                    r_rtrc <= '0;
                    r_mesi <= '0;
                end

                if (w_drop) begin
                    r_ovf <= 1'b1;
                    if (r_drop != 16'hFFFF) begin
                        r_drop <= r_drop + 16'd1;
                    end
                end
            end
        end

        assign s_mem_resp[8*c +: 8]   = r_resp;
        assign s_mem_rtrc[8*c +: 8]   = r_rtrc;
        assign s_mem_mesi[8*c +: 8]   = r_mesi;
        assign s_mem_ovf[c]           = r_ovf;
        assign s_mem_drop[16*c +: 16] = r_drop;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stub.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stub
// Purpose  : Scoreboard bench for mem_stub; two instances (LAT=1/DEPTH=2 and
//            LAT=3/DEPTH=4) share clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stub;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]   lock_a, lock_b;
    logic [15:0]  rqst_a, trsc_a, rqst_b, trsc_b;
    logic [127:0] addr_in;
    logic [15:0]  mjunk;
    logic [15:0]  resp_a, rtrc_a, mesi_a, resp_b, rtrc_b, mesi_b;
    logic [1:0]   ovf_a, ovf_b, mlock_a, mlock_b;
    logic [31:0]  drop_a, drop_b;
    logic [15:0]  mrqst_a, mtrsc_a, mrqst_b, mtrsc_b;
    logic [127:0] maddr_a, maddr_b;

    mem_stub #(.NCH(2), .LAT(1), .DEPTH(2), .MESI(8'h01)) dut_a (
        .clk(clk), .rst(rst),
        .s_mem_lock(lock_a), .s_mem_rqst(rqst_a), .s_mem_trsc(trsc_a),
        .s_mem_addr(addr_in),
        .s_mem_resp(resp_a), .s_mem_rtrc(rtrc_a), .s_mem_mesi(mesi_a),
        .s_mem_ovf(ovf_a), .s_mem_drop(drop_a),
        .m_mem_lock(mlock_a), .m_mem_rqst(mrqst_a), .m_mem_trsc(mtrsc_a),
        .m_mem_addr(maddr_a), .m_mem_resp(mjunk), .m_mem_mesi(mjunk)
    );

    mem_stub #(.NCH(2), .LAT(3), .DEPTH(4), .MESI(8'h03)) dut_b (
        .clk(clk), .rst(rst),
        .s_mem_lock(lock_b), .s_mem_rqst(rqst_b), .s_mem_trsc(trsc_b),
        .s_mem_addr(addr_in),
        .s_mem_resp(resp_b), .s_mem_rtrc(rtrc_b), .s_mem_mesi(mesi_b),
        .s_mem_ovf(ovf_b), .s_mem_drop(drop_b),
        .m_mem_lock(mlock_b), .m_mem_rqst(mrqst_b), .m_mem_trsc(mtrsc_b),
        .m_mem_addr(maddr_b), .m_mem_resp(mjunk), .m_mem_mesi(mjunk)
    );

    typedef struct {
        int         cyc;
        logic [7:0] r;
        logic [7:0] t;
    } exp_t;

    // Streams 0/1: dut_a channels, streams 2/3: dut_b channels.
    exp_t q_exp [4][$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input int s, input int c, input logic [7:0] r, input logic [7:0] t);
        exp_t e;
        e.cyc = c;
        e.r   = r;
        e.t   = t;
        q_exp[s].push_back(e);
    endtask

    task automatic req_a(input int ch, input logic [7:0] r, input logic [7:0] t);
        rqst_a[8*ch +: 8] = r;
        trsc_a[8*ch +: 8] = t;
    endtask

    task automatic req_b(input int ch, input logic [7:0] r, input logic [7:0] t);
        rqst_b[8*ch +: 8] = r;
        trsc_b[8*ch +: 8] = t;
    endtask

    task automatic idle();
        rqst_a = '0;
        rqst_b = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_resp"}, {resp_a, resp_b}, 0);
        chk({tag, "_rtrc"}, {rtrc_a, rtrc_b}, 0);
        chk({tag, "_mesi"}, {mesi_a, mesi_b}, 0);
        chk({tag, "_ovf"},  {ovf_a, ovf_b}, 0);
        chk({tag, "_drop"}, {drop_a, drop_b}, 0);
    endtask

    logic [7:0] obs_r, obs_t, obs_m, exp_m;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("master_tieoff", {63'd0, |{mlock_a, mrqst_a, mtrsc_a, maddr_a,
                                           mlock_b, mrqst_b, mtrsc_b, maddr_b}}, 0);
            for (int s = 0; s < 4; s++) begin
                obs_r = (s < 2) ? resp_a[8*s +: 8] : resp_b[8*(s-2) +: 8];
                obs_t = (s < 2) ? rtrc_a[8*s +: 8] : rtrc_b[8*(s-2) +: 8];
                obs_m = (s < 2) ? mesi_a[8*s +: 8] : mesi_b[8*(s-2) +: 8];
                exp_m = (s < 2) ? 8'h01 : 8'h03;
                while (q_exp[s].size() > 0 && q_exp[s][0].cyc < cyc) begin
                    mon_e = q_exp[s].pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_resp_s%0d: no response in cycle %0d, expected rqst %0h trsc %0h",
                             s, mon_e.cyc, mon_e.r, mon_e.t);
                end
                if (q_exp[s].size() > 0 && q_exp[s][0].cyc == cyc) begin
                    mon_e = q_exp[s].pop_front();
                    chk($sformatf("resp_s%0d", s), obs_r, mon_e.r);
                    chk($sformatf("rtrc_s%0d", s), obs_t, mon_e.t);
                    chk($sformatf("mesi_s%0d", s), obs_m, exp_m);
                end else begin
                    chk($sformatf("idle_s%0d", s), {obs_r, obs_t, obs_m}, 0);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (cyc > 95000) begin
            $display("FAIL timeout: cycle budget exceeded at %0d", cyc);
            $fatal(1, "timeout");
        end
    end

    localparam int N_SAT = 70000;

    initial begin
        int t;
        rst     = 1'b1;
        lock_a  = '0;
        lock_b  = '0;
        rqst_a  = 16'h0505;
        rqst_b  = 16'h0505;
        trsc_a  = 16'h1111;
        trsc_b  = 16'h1111;
        addr_in = {4{32'hDEAD_BEEF}};
        mjunk   = 16'hAAAA;

        // Reset held for three cycles with requests present.
        repeat (3) begin
            tick();
            mon_en = 1'b1;
            chk_zero("in_reset");
        end
        rst = 1'b0;
        idle();
        tick();
        chk_zero("post_reset");

        // LAT=1 bypass on both channels.
        t = cyc;
        req_a(0, 8'h05, 8'h11);
        req_a(1, 8'h07, 8'h22);
        exp_push(0, t + 1, 8'h05, 8'h11);
        exp_push(1, t + 1, 8'h07, 8'h22);
        tick();
        idle();
        repeat (2) tick();

        // LAT=3 ordering on dut_b, one-per-cycle stream on dut_a ch1.
        for (int i = 0; i < 4; i++) begin
            req_b(0, 8'(8'h01 + i), 8'(8'hA0 + i));
            exp_push(2, cyc + 3, 8'(8'h01 + i), 8'(8'hA0 + i));
            req_a(1, 8'(8'h90 + i), 8'(8'hB0 + i));
            exp_push(1, cyc + 1, 8'(8'h90 + i), 8'(8'hB0 + i));
            tick();
        end
        idle();
        repeat (5) tick();
        chk("b_drop", drop_b, 0);
        chk("b_ovf", ovf_b, 0);

        // Lock + overflow on dut_a ch0 (DEPTH=2): two queue, two drop.
        t = cyc;
        lock_a[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a(0, 8'(8'h31 + i), 8'(8'h40 + i));
            if (i < 2) exp_push(0, t + 5 + i, 8'(8'h31 + i), 8'(8'h40 + i));
            tick();
        end
        lock_a[0] = 1'b0;
        idle();
        chk("ovf_set", ovf_a, 2'b01);
        chk("drop_two", drop_a, 32'd2);
        repeat (4) tick();
        chk("ovf_sticky", ovf_a[0], 1);

        // Full FIFO with pop in the same cycle as a new request.
        t = cyc;
        lock_a[0] = 1'b1;
        req_a(0, 8'h51, 8'h60);
        tick();
        req_a(0, 8'h52, 8'h61);
        tick();
        lock_a[0] = 1'b0;
        req_a(0, 8'h53, 8'h62);
        exp_push(0, t + 3, 8'h51, 8'h60);
        exp_push(0, t + 4, 8'h52, 8'h61);
        exp_push(0, t + 5, 8'h53, 8'h62);
        tick();
        idle();
        chk("drop_unchanged", drop_a, 32'd2);
        repeat (4) tick();

        // Channel independence: ch0 locked five cycles while ch1 streams.
        t = cyc;
        lock_a[0] = 1'b1;
        req_a(0, 8'h71, 8'h80);
        for (int i = 0; i < 4; i++) begin
            req_a(1, 8'(8'hC0 + i), 8'(8'hD0 + i));
            exp_push(1, cyc + 1, 8'(8'hC0 + i), 8'(8'hD0 + i));
            tick();
            rqst_a[7:0] = 8'h00;
        end
        idle();
        tick();
        lock_a[0] = 1'b0;
        exp_push(0, t + 6, 8'h71, 8'h80);
        repeat (4) tick();

        // Reset with entries queued behind locks: nothing may emerge.
        lock_b    = 2'b11;
        lock_a[1] = 1'b1;
        req_b(0, 8'h41, 8'h42);
        req_b(1, 8'h43, 8'h44);
        req_a(1, 8'h45, 8'h46);
        tick();
        req_b(0, 8'h47, 8'h48);
        tick();
        rst = 1'b1;
        idle();
        tick();
        rst    = 1'b0;
        lock_a = '0;
        lock_b = '0;
        tick();
        chk("ovf_cleared", {ovf_a, ovf_b}, 0);
        chk("drop_cleared", drop_a, 0);
        repeat (6) tick();
        req_a(0, 8'h5A, 8'h5B);
        exp_push(0, cyc + 1, 8'h5A, 8'h5B);
        tick();
        idle();
        repeat (2) tick();

        // Drop counter saturation on dut_a ch0.
        t = cyc;
        lock_a[0] = 1'b1;
        req_a(0, 8'hFF, 8'hE0);
        exp_push(0, t + N_SAT + 1, 8'hFF, 8'hE0);
        tick();
        req_a(0, 8'hFF, 8'hE1);
        exp_push(0, t + N_SAT + 2, 8'hFF, 8'hE1);
        tick();
        repeat (N_SAT - 2) tick();
        lock_a[0] = 1'b0;
        idle();
        chk("drop_saturated", drop_a[15:0], 16'hFFFF);
        chk("drop_ch1_clean", drop_a[31:16], 0);
        chk("ovf_after_sat", ovf_a, 2'b01);
        repeat (5) tick();

        for (int s = 0; s < 4; s++) begin
            chk($sformatf("sb_empty_s%0d", s), q_exp[s].size(), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
